// File: rtl/fab_clk_enable_gen.sv
// Fabric clock-enable generator: a lock/settle counter plus NUM_CH programmable
// enable strobes with 50%-duty toggles and glitch-free divisor updates.
module fab_clk_enable_gen #(
    parameter int NUM_CH      = 3,
    parameter int DIV_W       = 16,
    parameter int LOCK_CYCLES = 1024,
    parameter int DEFAULT_DIV = 2
) (
    input  logic              FAB_CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DIV_WR,
    input  logic [DIV_W-1:0]  DIV_DATA,
    input  logic [NUM_CH-1:0] CH_EN,
    output logic [NUM_CH-1:0] CE_OUT,
    output logic [NUM_CH-1:0] TGL_OUT,
    output logic [NUM_CH-1:0] DIV_PEND,
    output logic              FAB_LOCK
);

    localparam int               LOCK_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_RST   = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);

    logic [LOCK_W-1:0] lock_cnt_reg;
    logic              lock_reg;
    logic [DIV_W-1:0]  div_wr_val;

    // The lock counter freezes once lock is reached, so it can never wrap.
    always_ff @(posedge FAB_CLK or posedge RESET) begin
        if (RESET) begin
            lock_cnt_reg <= '0;
            lock_reg     <= 1'b0;
        end else if (!lock_reg) begin
            if (lock_cnt_reg == LOCK_LAST) begin
                lock_reg <= 1'b1;
            end else begin
                lock_cnt_reg <= lock_cnt_reg + LOCK_W'(1);
            end
        end
    end

    assign FAB_LOCK = lock_reg;

    // A zero divisor is meaningless, so it is promoted to 1 (strobe every cycle).
    assign div_wr_val = (DIV_DATA == '0) ? DIV_ONE : DIV_DATA;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DIV_W-1:0] cnt_reg, cnt_next;
            logic [DIV_W-1:0] div_reg, div_next;
            logic [DIV_W-1:0] shd_reg, shd_next;
            logic             ce_reg, ce_next;
            logic             tgl_reg, tgl_next;
            logic             pend_reg, pend_next;
            logic             run;
            logic             tc;

            assign run = lock_reg & CH_EN[gi];
            assign tc  = (cnt_reg == div_reg - DIV_ONE);

            always_comb begin
                cnt_next  = cnt_reg;
                div_next  = div_reg;
                shd_next  = shd_reg;
                ce_next   = 1'b0;
                tgl_next  = tgl_reg;
                pend_next = pend_reg;
                if (!run) begin
                    // Idle channel: divisor tracks the latest write with no deferral.
                    cnt_next  = '0;
                    pend_next = 1'b0;
                    if (DIV_WR[gi]) begin
                        shd_next = div_wr_val;
                        div_next = div_wr_val;
                    end else begin
                        div_next = shd_reg;
                    end
                end else if (tc) begin
                    cnt_next  = '0;
                    ce_next   = 1'b1;
                    tgl_next  = ~tgl_reg;
                    pend_next = 1'b0;
                    if (DIV_WR[gi]) begin
                        shd_next = div_wr_val;
                        div_next = div_wr_val;
                    end else if (pend_reg) begin
                        div_next = shd_reg;
                    end
                end else begin
                    cnt_next = cnt_reg + DIV_ONE;
                    if (DIV_WR[gi]) begin
                        shd_next  = div_wr_val;
                        pend_next = 1'b1;
                    end
                end
            end

            always_ff @(posedge FAB_CLK or posedge RESET) begin
                if (RESET) begin
                    cnt_reg  <= '0;
                    div_reg  <= DIV_RST;
                    shd_reg  <= DIV_RST;
                    ce_reg   <= 1'b0;
                    tgl_reg  <= 1'b0;
                    pend_reg <= 1'b0;
                end else begin
                    cnt_reg  <= cnt_next;
                    div_reg  <= div_next;
                    shd_reg  <= shd_next;
                    ce_reg   <= ce_next;
                    tgl_reg  <= tgl_next;
                    pend_reg <= pend_next;
                end
            end

            assign CE_OUT[gi]   = ce_reg;
            assign TGL_OUT[gi]  = tgl_reg;
            assign DIV_PEND[gi] = pend_reg;
        end
    endgenerate

endmodule

// File: tb/tb_fab_clk_enable_gen.sv
// Bench for fab_clk_enable_gen: directed phases plus random traffic, checked
// every cycle against a pulse-schedule model of the channels.
module tb_fab_clk_enable_gen;

    localparam int NCH = 3;
    localparam int DW  = 16;
    localparam int LC  = 16;
    localparam int DEF = 2;

    logic           clk;
    logic           RESET;
    logic [NCH-1:0] DIV_WR;
    logic [DW-1:0]  DIV_DATA;
    logic [NCH-1:0] CH_EN;
    logic [NCH-1:0] CE_OUT;
    logic [NCH-1:0] TGL_OUT;
    logic [NCH-1:0] DIV_PEND;
    logic           FAB_LOCK;

    fab_clk_enable_gen #(
        .NUM_CH(NCH), .DIV_W(DW), .LOCK_CYCLES(LC), .DEFAULT_DIV(DEF)
    ) dut (
        .FAB_CLK (clk),
        .RESET   (RESET),
        .DIV_WR  (DIV_WR),
        .DIV_DATA(DIV_DATA),
        .CH_EN   (CH_EN),
        .CE_OUT  (CE_OUT),
        .TGL_OUT (TGL_OUT),
        .DIV_PEND(DIV_PEND),
        .FAB_LOCK(FAB_LOCK)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: absolute edge number since reset release, and per channel the
    // period in force, the edge of the next scheduled pulse, and any deferred value.
    int cyc;
    bit m_lock;
    int m_per  [NCH];
    int m_shd  [NCH];
    int m_next [NCH];
    bit m_pend [NCH];
    bit m_idle [NCH];
    bit m_tgl  [NCH];
    bit m_ce   [NCH];

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        cyc    = 0;
        m_lock = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            m_per[c]  = DEF;
            m_shd[c]  = DEF;
            m_next[c] = 0;
            m_pend[c] = 1'b0;
            m_idle[c] = 1'b1;
            m_tgl[c]  = 1'b0;
            m_ce[c]   = 1'b0;
        end
    endtask

    // Advance the model by one edge using the inputs now applied, clock the DUT, compare.
    task automatic step();
        int fix;
        bit run;
        logic [NCH-1:0] e_ce, e_tgl, e_pend;
        cyc++;
        fix = (DIV_DATA == '0) ? 1 : int'(DIV_DATA);
        for (int c = 0; c < NCH; c++) begin
            run = m_lock && CH_EN[c];
            if (!run) begin
                m_idle[c] = 1'b1;
                m_ce[c]   = 1'b0;
                m_pend[c] = 1'b0;
                if (DIV_WR[c]) m_shd[c] = fix;
                m_per[c] = m_shd[c];
            end else begin
                if (m_idle[c]) begin
                    m_idle[c] = 1'b0;
                    m_next[c] = cyc + m_per[c] - 1;
                end
                if (cyc == m_next[c]) begin
                    m_ce[c]  = 1'b1;
                    m_tgl[c] = ~m_tgl[c];
                    if (DIV_WR[c]) begin
                        m_per[c] = fix;
                        m_shd[c] = fix;
                    end else if (m_pend[c]) begin
                        m_per[c] = m_shd[c];
                    end
                    m_pend[c] = 1'b0;
                    m_next[c] = cyc + m_per[c];
                end else begin
                    m_ce[c] = 1'b0;
                    if (DIV_WR[c]) begin
                        m_shd[c]  = fix;
                        m_pend[c] = 1'b1;
                    end
                end
            end
        end
        if (cyc >= LC) m_lock = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < NCH; c++) begin
            e_ce[c]   = m_ce[c];
            e_tgl[c]  = m_tgl[c];
            e_pend[c] = m_pend[c];
        end
        chk("ce_out",   8'(CE_OUT),   8'(e_ce));
        chk("tgl_out",  8'(TGL_OUT),  8'(e_tgl));
        chk("div_pend", 8'(DIV_PEND), 8'(e_pend));
        chk("fab_lock", 8'(FAB_LOCK), 8'(m_lock));
    endtask

    task automatic wr(input logic [NCH-1:0] mask, input int data);
        DIV_WR   = mask;
        DIV_DATA = DW'(data);
        $display("cyc=%0d write mask=%b data=%0d en=%b", cyc + 1, mask, data, CH_EN);
        step();
        DIV_WR = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ce"},   8'(CE_OUT),   8'h00);
        chk({tag, "_tgl"},  8'(TGL_OUT),  8'h00);
        chk({tag, "_pend"}, 8'(DIV_PEND), 8'h00);
        chk({tag, "_lock"}, 8'(FAB_LOCK), 8'h00);
    endtask

    initial begin
        int n;
        RESET    = 1'b1;
        DIV_WR   = '0;
        DIV_DATA = '0;
        CH_EN    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        RESET = 1'b0;

        $display("phase: lock and default divisor");
        CH_EN = 3'b111;
        repeat (30) step();

        $display("phase: ch0 divisor update at terminal count");
        wr(3'b001, 5);
        repeat (12) step();
        wr(3'b001, 3);
        repeat (20) step();

        $display("phase: ch1 write coinciding with terminal count, then zero divisor");
        wr(3'b010, 4);
        repeat (10) step();
        n = 0;
        while (m_next[1] != cyc + 1 && n < 20) begin
            step();
            n++;
        end
        chk("tc_found", 8'(n < 20), 8'h01);
        wr(3'b010, 7);
        repeat (20) step();
        wr(3'b010, 0);
        repeat (10) step();

        $display("phase: ch2 written while disabled");
        CH_EN[2] = 1'b0;
        step();
        wr(3'b100, 10);
        repeat (5) step();
        CH_EN[2] = 1'b1;
        repeat (25) step();

        $display("phase: random traffic");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) CH_EN = NCH'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) begin
                wr(NCH'($urandom_range(1, 7)), int'($urandom_range(0, 9)));
            end else begin
                step();
            end
        end

        $display("phase: asynchronous reset mid-operation");
        CH_EN = 3'b111;
        wr(3'b111, 12);
        repeat (3) step();
        wr(3'b111, 9);
        #2;
        RESET = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        chk_reset_outputs("held_rst");
        RESET = 1'b0;
        model_reset();
        repeat (30) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
